// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack: registered top-of-stack plus a DEPTH-1 entry array.
// Supports push, pop, replace (push+pop), flush and sticky overflow/underflow flags.
module param_lifo_stack #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 32,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sig_push,
  input  logic                  sig_pop,
  input  logic                  flush,
  input  logic                  clear_errors,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  flag_full,
  output logic                  flag_empty,
  output logic                  flag_overflow,
  output logic                  flag_underflow
);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  // Entry i holds the word that sits at stack position i+1 (the top lives in DataOut).
  logic [DATA_WIDTH-1:0] below_mem [DEPTH-1];
  logic [DATA_WIDTH-1:0] below_top;
  logic [DATA_WIDTH-1:0] top_next;
  logic [CNT_WIDTH-1:0]  count_next;
  logic                  spill;
  logic                  ovf_evt;
  logic                  unf_evt;

  assign flag_full  = (count == FULL_CNT);
  assign flag_empty = (count == '0);

  // Word directly beneath the current top; zero when one or fewer words are held.
  always_comb begin
    below_top = '0;
    for (int unsigned i = 0; i < unsigned'(DEPTH - 1); i++) begin
      if (count == CNT_WIDTH'(i + 2)) below_top = below_mem[i];
    end
  end

  always_comb begin
    count_next = count;
    top_next   = DataOut;
    spill      = 1'b0;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    if (flush) begin
      count_next = '0;
      top_next   = '0;
    end else if (sig_push && !sig_pop) begin
      if (flag_full) begin
        ovf_evt = 1'b1;
      end else begin
        spill      = !flag_empty;
        count_next = count + CNT_WIDTH'(1);
        top_next   = DataIn;
      end
    end else if (sig_pop && !sig_push) begin
      if (flag_empty) begin
        unf_evt = 1'b1;
      end else begin
        count_next = count - CNT_WIDTH'(1);
        top_next   = below_top;
      end
    end else if (sig_push && sig_pop) begin
      top_next = DataIn;
      if (flag_empty) count_next = CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count          <= '0;
      DataOut        <= '0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
    end else begin
      count          <= count_next;
      DataOut        <= top_next;
      flag_overflow  <= (flag_overflow  & ~clear_errors) | ovf_evt;
      flag_underflow <= (flag_underflow & ~clear_errors) | unf_evt;
    end
  end

  // On a push the old top moves into the slot just below the new top.
  always_ff @(posedge clock) begin
    if (spill) begin
      for (int unsigned i = 0; i < unsigned'(DEPTH - 1); i++) begin
        if (count == CNT_WIDTH'(i + 1)) below_mem[i] <= DataOut;
      end
    end
  end

endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed bench for param_lifo_stack (8x4 instance) plus a randomised
// queue-model comparison on a 13x5 instance.
module tb_param_lifo_stack;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       a_push, a_pop, a_flush, a_clr;
  logic [7:0] a_din, a_dout;
  logic [2:0] a_cnt;
  logic       a_full, a_empty, a_ovf, a_unf;

  logic        b_push, b_pop, b_flush, b_clr;
  logic [12:0] b_din, b_dout;
  logic [2:0]  b_cnt;
  logic        b_full, b_empty, b_ovf, b_unf;

  param_lifo_stack #(.DATA_WIDTH(8), .DEPTH(4)) u_a (
    .clock(clk), .reset(rst), .sig_push(a_push), .sig_pop(a_pop), .flush(a_flush),
    .clear_errors(a_clr), .DataIn(a_din), .DataOut(a_dout), .count(a_cnt),
    .flag_full(a_full), .flag_empty(a_empty), .flag_overflow(a_ovf), .flag_underflow(a_unf)
  );

  param_lifo_stack #(.DATA_WIDTH(13), .DEPTH(5)) u_b (
    .clock(clk), .reset(rst), .sig_push(b_push), .sig_pop(b_pop), .flush(b_flush),
    .clear_errors(b_clr), .DataIn(b_din), .DataOut(b_dout), .count(b_cnt),
    .flag_full(b_full), .flag_empty(b_empty), .flag_overflow(b_ovf), .flag_underflow(b_unf)
  );

  task automatic a_op(input logic pu, input logic po, input logic fl, input logic cl,
                      input logic [7:0] d);
    a_push = pu; a_pop = po; a_flush = fl; a_clr = cl; a_din = d;
    @(posedge clk); #1;
    a_push = 1'b0; a_pop = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
  endtask

  task automatic test_reset();
    a_push = 1'b1; a_din = 8'hEE;
    @(posedge clk); #1;
    tests++; if (a_cnt !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
    tests++; if (a_dout !== 8'h00) begin fails++; $display("FAIL reset_dout got %h exp 00", a_dout); end
    tests++; if ({a_empty, a_full, a_ovf, a_unf} !== 4'b1000) begin fails++;
      $display("FAIL reset_flags got %b exp 1000", {a_empty, a_full, a_ovf, a_unf}); end
    a_push = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (a_cnt !== 3'd0) begin fails++; $display("FAIL post_reset_idle got %0d exp 0", a_cnt); end
  endtask

  task automatic test_push_fill();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      a_op(1'b1, 1'b0, 1'b0, 1'b0, vals[i]);
      tests++; if (a_cnt !== 3'(i + 1)) begin fails++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, a_cnt, i + 1); end
      tests++; if (a_dout !== vals[i]) begin fails++; $display("FAIL fill_dout[%0d] got %h exp %h", i, a_dout, vals[i]); end
      tests++; if (a_full !== (i == 3)) begin fails++; $display("FAIL fill_full[%0d] got %b exp %b", i, a_full, i == 3); end
    end
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    tests++; if (a_cnt !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d exp 4", a_cnt); end
    tests++; if (a_dout !== 8'h44) begin fails++; $display("FAIL ovf_dout got %h exp 44", a_dout); end
    tests++; if ({a_ovf, a_unf} !== 2'b10) begin fails++; $display("FAIL ovf_flags got %b exp 10", {a_ovf, a_unf}); end
  endtask

  task automatic test_pop_drain();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h33; exp_d[1] = 8'h22; exp_d[2] = 8'h11; exp_d[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      a_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      tests++; if (a_dout !== exp_d[i]) begin fails++; $display("FAIL drain_dout[%0d] got %h exp %h", i, a_dout, exp_d[i]); end
      tests++; if (a_cnt !== 3'(3 - i)) begin fails++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, a_cnt, 3 - i); end
    end
    tests++; if ({a_empty, a_full} !== 2'b10) begin fails++; $display("FAIL drain_empty got %b exp 10", {a_empty, a_full}); end
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tests++; if ({a_cnt, a_ovf, a_unf} !== {3'd0, 2'b11}) begin fails++;
      $display("FAIL unf_state got %0d/%b%b exp 0/11", a_cnt, a_ovf, a_unf); end
    a_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tests++; if ({a_ovf, a_unf} !== 2'b00) begin fails++; $display("FAIL clear_errors got %b exp 00", {a_ovf, a_unf}); end
    // clear_errors alongside a fresh underflow: set wins
    a_op(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    tests++; if ({a_ovf, a_unf} !== 2'b01) begin fails++; $display("FAIL clear_vs_set got %b exp 01", {a_ovf, a_unf}); end
    a_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_replace();
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
    a_op(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
    tests++; if ({a_cnt, a_dout} !== {3'd2, 8'hAA}) begin fails++; $display("FAIL replace got %0d/%h exp 2/aa", a_cnt, a_dout); end
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tests++; if ({a_cnt, a_dout} !== {3'd1, 8'h11}) begin fails++; $display("FAIL replace_pop got %0d/%h exp 1/11", a_cnt, a_dout); end
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    a_op(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    tests++; if ({a_cnt, a_dout, a_unf} !== {3'd1, 8'h5A, 1'b0}) begin fails++;
      $display("FAIL replace_empty got %0d/%h/%b exp 1/5a/0", a_cnt, a_dout, a_unf); end
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'hB1);
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'hB2);
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'hB3);
    a_op(1'b1, 1'b1, 1'b0, 1'b0, 8'hCC);
    tests++; if ({a_cnt, a_dout, a_ovf} !== {3'd4, 8'hCC, 1'b0}) begin fails++;
      $display("FAIL replace_full got %0d/%h/%b exp 4/cc/0", a_cnt, a_dout, a_ovf); end
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tests++; if ({a_cnt, a_dout} !== {3'd3, 8'hB2}) begin fails++; $display("FAIL replace_full_pop got %0d/%h exp 3/b2", a_cnt, a_dout); end
  endtask

  task automatic test_flush();
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'hD4);
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'hD5);
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tests++; if ({a_cnt, a_ovf} !== {3'd3, 1'b1}) begin fails++; $display("FAIL flush_setup got %0d/%b exp 3/1", a_cnt, a_ovf); end
    a_op(1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
    tests++; if ({a_cnt, a_dout, a_empty, a_ovf} !== {3'd0, 8'h00, 2'b11}) begin fails++;
      $display("FAIL flush got %0d/%h/%b%b exp 0/00/11", a_cnt, a_dout, a_empty, a_ovf); end
  endtask

  task automatic test_async_reset();
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    tests++; if (a_cnt !== 3'd3) begin fails++; $display("FAIL areset_setup got %0d exp 3", a_cnt); end
    #3 rst = 1'b1;
    #1;
    tests++; if ({a_cnt, a_dout, a_empty, a_ovf} !== {3'd0, 8'h00, 2'b10}) begin fails++;
      $display("FAIL areset got %0d/%h/%b%b exp 0/00/10", a_cnt, a_dout, a_empty, a_ovf); end
    #2 rst = 1'b0;
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
    tests++; if ({a_cnt, a_dout} !== {3'd1, 8'h99}) begin fails++; $display("FAIL areset_push got %0d/%h exp 1/99", a_cnt, a_dout); end
  endtask

  task automatic test_back_to_back();
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'hA2);
    tests++; if ({a_cnt, a_dout} !== {3'd1, 8'hA2}) begin fails++; $display("FAIL pop_then_push got %0d/%h exp 1/a2", a_cnt, a_dout); end
    a_op(1'b1, 1'b0, 1'b0, 1'b0, 8'hA3);
    a_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tests++; if ({a_cnt, a_dout} !== {3'd1, 8'hA2}) begin fails++; $display("FAIL alt_pop got %0d/%h exp 1/a2", a_cnt, a_dout); end
    a_push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_din = 8'hC0 + 8'(i);
      @(posedge clk); #1;
      tests++; if ({a_cnt, a_dout} !== {3'(i + 2), 8'hC0 + 8'(i)}) begin fails++;
        $display("FAIL held_push[%0d] got %0d/%h exp %0d/%h", i, a_cnt, a_dout, i + 2, 8'hC0 + 8'(i)); end
    end
    a_push = 1'b0;
    tests++; if ({a_full, a_ovf} !== 2'b10) begin fails++; $display("FAIL held_push_full got %b exp 10", {a_full, a_ovf}); end
  endtask

  task automatic test_random();
    logic [12:0] mdl [$];
    logic        movf, munf, ov, un, pu, po, fl, cl;
    logic [12:0] d, exp_d;
    logic [31:0] r;
    movf = 1'b0; munf = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      r = $urandom;
      pu = r[0]; po = r[1]; fl = (r[7:4] == 4'd0); cl = (r[10:8] == 3'd0); d = r[28:16];
      b_push = pu; b_pop = po; b_flush = fl; b_clr = cl; b_din = d;
      @(posedge clk); #1;
      ov = 1'b0; un = 1'b0;
      if (fl) mdl.delete();
      else if (pu && !po) begin
        if (mdl.size() == 5) ov = 1'b1; else mdl.push_back(d);
      end else if (po && !pu) begin
        if (mdl.size() == 0) un = 1'b1; else void'(mdl.pop_back());
      end else if (pu && po) begin
        if (mdl.size() == 0) mdl.push_back(d); else mdl[mdl.size() - 1] = d;
      end
      movf = (movf && !cl) || ov;
      munf = (munf && !cl) || un;
      exp_d = (mdl.size() > 0) ? mdl[mdl.size() - 1] : 13'd0;
      tests++;
      if ({b_dout, b_cnt, b_full, b_empty, b_ovf, b_unf} !==
          {exp_d, 3'(mdl.size()), mdl.size() == 5, mdl.size() == 0, movf, munf}) begin
        fails++;
        $display("FAIL random[%0d] got %h/%0d/%b%b%b%b exp %h/%0d/%b%b%b%b", c,
                 b_dout, b_cnt, b_full, b_empty, b_ovf, b_unf,
                 exp_d, mdl.size(), mdl.size() == 5, mdl.size() == 0, movf, munf);
      end
    end
    b_push = 1'b0; b_pop = 1'b0; b_flush = 1'b0; b_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_push = 1'b0; a_pop = 1'b0; a_flush = 1'b0; a_clr = 1'b0; a_din = '0;
    b_push = 1'b0; b_pop = 1'b0; b_flush = 1'b0; b_clr = 1'b0; b_din = '0;
    test_reset();
    test_push_fill();
    test_pop_drain();
    test_replace();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without completing");
    $fatal(1);
  end

endmodule

// File: doc/param_lifo_stack.md
# param_lifo_stack

Parametrised last-in-first-out store for the processor's call/return and operand-stack paths, replacing the fixed 32×32 stack. It holds DEPTH words of DATA_WIDTH bits and presents the current top of stack on a registered output at all times. It adds simultaneous push+pop (replace top), occupancy count, synchronous flush, and sticky overflow/underflow error flags. It sits between the control unit (push/pop strobes) and the PC/ALU datapath.

## Interface
- DATA_WIDTH, 32, word width in bits (≥1)
- DEPTH, 32, number of storable words (≥2; non-power-of-2 allowed; all DEPTH entries usable)
- CNT_WIDTH, $clog2(DEPTH+1), derived localparam, width of count; not overridable
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- sig_push  input  1  push DataIn this cycle
- sig_pop  input  1  pop top this cycle
- flush  input  1  synchronous empty; priority over push/pop
- clear_errors  input  1  synchronous clear of sticky error flags
- DataIn  input  DATA_WIDTH  word to push
- DataOut  output  DATA_WIDTH  current top of stack (registered); 0 when empty
- count  output  CNT_WIDTH  number of stored words, 0..DEPTH
- flag_full  output  1  count == DEPTH
- flag_empty  output  1  count == 0
- flag_overflow  output  1  sticky: push attempted while full without pop
- flag_underflow  output  1  sticky: pop attempted while empty

## Operation
- Reset (async, any time, including mid-operation): count=0, DataOut=0, flag_overflow=0, flag_underflow=0; flag_empty=1, flag_full=0. Storage contents need not be cleared. Push/pop asserted during reset are ignored; first operation takes effect at the first rising edge after reset deasserts.
- Per-edge action, evaluated in priority order:
  - flush=1: count←0, DataOut←0; push/pop ignored; error flags unaffected except by clear_errors.
  - push=1, pop=0, not full: store DataIn as new top; count+1; DataOut←DataIn.
  - push=1, pop=0, full: no state change; flag_overflow←1.
  - pop=1, push=0, count≥2: remove top; count−1; DataOut←word beneath old top.
  - pop=1, push=0, count==1: count←0; DataOut←0.
  - pop=1, push=0, empty: no state change; flag_underflow←1.
  - push=1, pop=1, non-empty (including full): replace top with DataIn; count unchanged; DataOut←DataIn; no error flags.
  - push=1, pop=1, empty: treated as plain push (count←1, DataOut←DataIn); no underflow.
  - neither: hold.
- clear_errors=1 clears both sticky flags. If an error event occurs in the same cycle, set wins (flag reads 1 after the edge).
- Data ordering is strict LIFO: the k-th pop after N pushes returns the (N−k+1)-th pushed word. Replace does not disturb entries beneath the top.
- count never wraps; flag_full and flag_empty are decoded combinationally from the count register only (no input-to-output combinational path).

## Timing
- All outputs change only on a rising clock edge or on reset assertion; none depends combinationally on inputs.
- Push/pop/replace latency: 1 cycle; the new DataOut/count/flags are valid immediately after the edge that samples the strobe.
- Back-to-back operations every cycle are supported at full rate, including alternating push/pop and pop-to-empty followed by push on the next cycle.
- No handshake: strobes are single-cycle qualified by clock; holding a strobe high for N cycles performs N operations.
- Storage read for the post-pop top must not add a cycle; a registered top plus a DEPTH−1 array is acceptable, provided observable behaviour matches the above.

## Test plan
- DATA_WIDTH=8, DEPTH=4: reset, push 0x11,0x22,0x33,0x44 -> count 1,2,3,4, DataOut follows each push, flag_full=1 after 4th; 5th push 0x55 -> count stays 4, DataOut 0x44, flag_overflow=1.
- From full: 4 pops -> DataOut 0x33,0x22,0x11,0x00, count 3..0, flag_empty=1; 5th pop -> flag_underflow=1, count 0; clear_errors -> both flags 0 next cycle.
- Stack [0x11,0x22]: push+pop with 0xAA -> count 2, DataOut 0xAA; pop -> DataOut 0x11. Empty: push+pop with 0x5A -> count 1, DataOut 0x5A, no underflow.
- Stack of 3: flush together with push 0x77 -> count 0, DataOut 0, flag_empty=1; overflow flag set earlier stays 1.
- Assert reset asynchronously mid-cycle with count 3 -> outputs go to reset values before the next edge; push 0x99 after release -> count 1, DataOut 0x99.
- Random push/pop/replace/flush for 10k cycles at DEPTH=5, DATA_WIDTH=13 against a scoreboard model -> DataOut, count, flags match every cycle.
